// File: rtl/raven_bus_pkg.sv
// Shared definitions for the 68000 local-bus responder: FSM states, address
// regions, the A23..A20 address map and the region decoder.
package raven_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } bus_state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_e;

  localparam logic [3:0] ROM_ADDR    = 4'h0;
  localparam logic [3:0] RAM_ADDR_LO = 4'h1;
  localparam logic [3:0] RAM_ADDR_HI = 4'h7;
  localparam logic [3:0] IO_ADDR     = 4'hF;

  // Everything the responder needs to remember about the cycle in progress.
  typedef struct packed {
    region_e region;
    logic    rw;
    logic    uds_n;
    logic    lds_n;
  } bus_req_t;

  localparam bus_req_t REQ_IDLE = '{region: REG_NONE, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1};

  function automatic region_e decode_region(input logic [3:0] addr_hi);
    region_e r;
    r = REG_NONE;
    if (addr_hi == ROM_ADDR) begin
      r = REG_ROM;
    end else if (addr_hi >= RAM_ADDR_LO && addr_hi <= RAM_ADDR_HI) begin
      r = REG_RAM;
    end else if (addr_hi == IO_ADDR) begin
      r = REG_IO;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer. Resets to 1 so an active-low strobe reads
// as inactive while reset is held.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from before the edge, giving a true two-stage chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus responder: decodes A23..A20 into ROM/RAM/IO selects, counts
// per-region wait states, then returns DTACK, or BERR after a timeout.
module m68k_bus_responder
  import raven_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned IO_WAIT      = 4,
  parameter int unsigned BERR_TIMEOUT = 32,
  parameter int unsigned CNT_W        = 6
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       as_n,
  input  logic       rw,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic [3:0] addr_hi,
  output logic       dtack_n,
  output logic       berr_n,
  output logic       rom_ce_n,
  output logic       ram_ce_n,
  output logic       io_ce_n,
  output logic       oe_n,
  output logic       we_hi_n,
  output logic       we_lo_n
);

  localparam logic [CNT_W-1:0] CNT_ROM  = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] CNT_RAM  = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] CNT_IO   = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] CNT_BERR = CNT_W'(BERR_TIMEOUT);

  function automatic logic [CNT_W-1:0] load_value(input region_e r);
    logic [CNT_W-1:0] v;
    case (r)
      REG_ROM: v = CNT_ROM;
      REG_RAM: v = CNT_RAM;
      REG_IO:  v = CNT_IO;
      default: v = CNT_BERR;
    endcase
    return v;
  endfunction

  logic             as_s;
  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_req_t         req_q, req_d;

  logic dtack_d, berr_d, rom_ce_d, ram_ce_d, io_ce_d, oe_d, we_hi_d, we_lo_d;

  sync2 u_as_sync (
    .clk (clk_in),
    .rst (reset),
    .d   (as_n),
    .q   (as_s)
  );

  // State register. Outputs are registered too, so reset releases them at
  // once without waiting for a clock edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= REQ_IDLE;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      rom_ce_n <= 1'b1;
      ram_ce_n <= 1'b1;
      io_ce_n  <= 1'b1;
      oe_n     <= 1'b1;
      we_hi_n  <= 1'b1;
      we_lo_n  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      dtack_n  <= dtack_d;
      berr_n   <= berr_d;
      rom_ce_n <= rom_ce_d;
      ram_ce_n <= ram_ce_d;
      io_ce_n  <= io_ce_d;
      oe_n     <= oe_d;
      we_hi_n  <= we_hi_d;
      we_lo_n  <= we_lo_d;
    end
  end

  // Next-state logic. The CPU qualifiers are only sampled in IDLE once the
  // synchronized strobe is low, by which point they are stable.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (!as_s) begin
          req_d   = '{region: decode_region(addr_hi), rw: rw, uds_n: uds_n, lds_n: lds_n};
          cnt_d   = load_value(decode_region(addr_hi));
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = (req_q.region == REG_NONE) ? ST_BERR : ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK, ST_BERR: begin
        if (as_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, evaluated on the next state so the registered strobes
  // change on the same edge as the state they belong to.
  always_comb begin
    logic sel;
    sel      = (state_d == ST_WAIT || state_d == ST_ACK) && (req_d.region != REG_NONE);
    dtack_d  = !(state_d == ST_ACK);
    berr_d   = !(state_d == ST_BERR);
    rom_ce_d = !(sel && req_d.region == REG_ROM);
    ram_ce_d = !(sel && req_d.region == REG_RAM);
    io_ce_d  = !(sel && req_d.region == REG_IO);
    // rw splits read and write, so oe_n and the write enables never overlap.
    oe_d     = !(sel && req_d.rw);
    we_hi_d  = !(sel && !req_d.rw && !req_d.uds_n);
    we_lo_d  = !(sel && !req_d.rw && !req_d.lds_n);
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: table of bus cycles with expected
// strobes and termination edge, plus reset, abort and mid-wait reset cases.
module tb_m68k_bus_responder;
  import raven_bus_pkg::*;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       as_n   = 1'b1;
  logic       rw     = 1'b1;
  logic       uds_n  = 1'b1;
  logic       lds_n  = 1'b1;
  logic [3:0] addr_hi = 4'h0;
  logic dtack_n, berr_n, rom_ce_n, ram_ce_n, io_ce_n, oe_n, we_hi_n, we_lo_n;

  int checks = 0;
  int errors = 0;

  m68k_bus_responder dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .as_n     (as_n),
    .rw       (rw),
    .uds_n    (uds_n),
    .lds_n    (lds_n),
    .addr_hi  (addr_hi),
    .dtack_n  (dtack_n),
    .berr_n   (berr_n),
    .rom_ce_n (rom_ce_n),
    .ram_ce_n (ram_ce_n),
    .io_ce_n  (io_ce_n),
    .oe_n     (oe_n),
    .we_hi_n  (we_hi_n),
    .we_lo_n  (we_lo_n)
  );

  always #5 clk_in = ~clk_in;

  // {dtack_n, berr_n, rom_ce_n, ram_ce_n, io_ce_n, oe_n, we_hi_n, we_lo_n}
  logic [7:0] all_act;
  assign all_act = {dtack_n, berr_n, rom_ce_n, ram_ce_n, io_ce_n, oe_n, we_hi_n, we_lo_n};

  typedef struct {
    string      name;
    logic [3:0] addr;
    logic       rw;
    logic       uds_n;
    logic       lds_n;
    logic [5:0] exp_sel;   // {rom, ram, io, oe, we_hi, we_lo}
    int         term_edge; // edge after which dtack_n/berr_n is low
    logic [1:0] exp_term;  // {dtack_n, berr_n} once terminated
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_access(input vec_t v);
    @(negedge clk_in);
    addr_hi = v.addr;
    rw      = v.rw;
    uds_n   = v.uds_n;
    lds_n   = v.lds_n;
    as_n    = 1'b0;
    for (int k = 0; k <= v.term_edge; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 1) check({v.name, " quiet"}, all_act, 8'hFF);
      if (k == 2) check({v.name, " select"}, all_act, {2'b11, v.exp_sel});
      if (k == v.term_edge - 1 && k != 2) check({v.name, " preterm"}, all_act, {2'b11, v.exp_sel});
      if (k == v.term_edge) check({v.name, " term"}, all_act, {v.exp_term, v.exp_sel});
    end
    @(negedge clk_in);
    as_n = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check({v.name, " hold"}, all_act, {v.exp_term, v.exp_sel});
    @(posedge clk_in);
    #1;
    check({v.name, " release"}, all_act, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"rom_rd",    4'h0, 1'b1, 1'b0, 1'b0, 6'b011011, 5,  2'b01};
    vecs[1] = '{"ram_wr_lo", 4'h3, 1'b0, 1'b1, 1'b0, 6'b101110, 3,  2'b01};
    vecs[2] = '{"ram_wr_w",  4'h7, 1'b0, 1'b0, 1'b0, 6'b101100, 3,  2'b01};
    vecs[3] = '{"ram_rd",    4'h1, 1'b1, 1'b0, 1'b0, 6'b101011, 3,  2'b01};
    vecs[4] = '{"io_rd",     4'hF, 1'b1, 1'b0, 1'b0, 6'b110011, 7,  2'b01};
    vecs[5] = '{"io_wr_hi",  4'hF, 1'b0, 1'b0, 1'b1, 6'b110101, 7,  2'b01};
    vecs[6] = '{"unmap_9",   4'h9, 1'b1, 1'b0, 1'b0, 6'b111111, 35, 2'b10};
    vecs[7] = '{"unmap_8",   4'h8, 1'b0, 1'b0, 1'b0, 6'b111111, 35, 2'b10};

    // Reset held while the strobe toggles: nothing may respond.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      as_n = ~as_n;
      @(posedge clk_in);
      #1;
      check("reset_hold", all_act, 8'hFF);
    end
    @(negedge clk_in);
    as_n  = 1'b1;
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    check("reset_idle_state", dut.state_q, ST_IDLE);
    check("reset_idle_out", all_act, 8'hFF);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i]);
    end

    // IO read aborted after edge 4: the abort lands on the edge where the
    // counter would otherwise have reached ACK.
    @(negedge clk_in);
    addr_hi = 4'hF;
    rw      = 1'b1;
    uds_n   = 1'b0;
    lds_n   = 1'b0;
    as_n    = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 2) check("abort_select", all_act, 8'b11_110011);
      if (k >= 5) check("abort_no_dtack", dtack_n, 1'b1);
      if (k == 6) check("abort_io_still_low", io_ce_n, 1'b0);
      if (k == 7) check("abort_release", all_act, 8'hFF);
      if (k == 7) check("abort_state", dut.state_q, ST_IDLE);
      if (k == 4) begin
        @(negedge clk_in);
        as_n = 1'b1;
      end
    end

    // Reset asserted while a RAM word write is waiting.
    @(negedge clk_in);
    addr_hi = 4'h2;
    rw      = 1'b0;
    uds_n   = 1'b0;
    lds_n   = 1'b0;
    as_n    = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("midreset_select", all_act, 8'b11_101100);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_async", all_act, 8'hFF);
    check("midreset_state", dut.state_q, ST_IDLE);
    @(negedge clk_in);
    as_n = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    run_access('{"after_reset", 4'h2, 1'b1, 1'b0, 1'b0, 6'b101011, 3, 2'b01});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
